// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - processor-side controller for the synchronous data RAM
// Clears every word after reset, then serves single-word read/write requests.
module ram_ctrl #(
  parameter int                DATA_W    = 3,
  parameter int                ADDR_W    = 3,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter bit                CLEAR_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RD_CAP = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  localparam logic [2:0]        S_RESET   = CLEAR_EN ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic [DATA_W-1:0] r_rdata;

  logic              w_we;
  logic              w_enable;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RESET;
      r_clr_cnt <= '0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            r_addr_q <= addr;
            if (wr) begin
              r_wdata_q <= wdata;
              r_state   <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_WR:     r_state <= S_ACK;
        S_RD:     r_state <= S_RD_CAP;
        // RAM registered its output at the end of S_RD; take it now.
        S_RD_CAP: begin
          r_rdata <= mem_data_out;
          r_state <= S_ACK;
        end
        S_ACK:    r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_we      = 1'b0;
    w_enable  = 1'b0;
    w_addr    = r_addr_q;
    w_data_in = r_wdata_q;
    case (r_state)
      S_CLEAR: begin
        w_we      = 1'b1;
        w_enable  = 1'b1;
        w_addr    = r_clr_cnt;
        w_data_in = CLEAR_VAL;
      end
      S_WR: begin
        w_we     = 1'b1;
        w_enable = 1'b1;
      end
      default: ;
    endcase
    // The RAM has no reset of its own, so keep it quiet while we are held.
    if (!reset_n) begin
      w_we      = 1'b0;
      w_enable  = 1'b0;
      w_addr    = '0;
      w_data_in = '0;
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign ack         = (r_state == S_ACK);
  assign rdata       = r_rdata;
  assign mem_we      = w_we;
  assign mem_enable  = w_enable;
  assign mem_addr    = w_addr;
  assign mem_data_in = w_data_in;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - self-checking bench for ram_ctrl
// Transaction-level model (edge counts, shadow memory) checked every cycle, plus directed literals.
module tb_ram_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] addr = '0;
  logic [2:0] wdata = '0;
  logic       ready, ack;
  logic [2:0] rdata;
  logic       mem_we, mem_enable;
  logic [2:0] mem_addr, mem_data_in, mem_data_out;

  logic       rst1_n = 1'b0;
  logic       ready1, ack1, mem_we1, mem_enable1;
  logic [2:0] rdata1, mem_addr1, mem_data_in1;
  logic [2:0] zero3 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_ctrl #(.DATA_W(3), .ADDR_W(3), .DEPTH(8), .CLEAR_VAL(3'd0), .CLEAR_EN(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .ack(ack), .rdata(rdata), .mem_we(mem_we), .mem_enable(mem_enable),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  ram_ctrl #(.DATA_W(3), .ADDR_W(3), .DEPTH(8), .CLEAR_VAL(3'd0), .CLEAR_EN(1'b0)) u_noclr (
    .clock(clock), .reset_n(rst1_n), .req(1'b0), .wr(1'b0), .addr(zero3), .wdata(zero3),
    .ready(ready1), .ack(ack1), .rdata(rdata1), .mem_we(mem_we1), .mem_enable(mem_enable1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_data_out(zero3)
  );

  // Synchronous RAM with no reset; seeded with nonzero junk so the sweep matters.
  logic [2:0] ram [8];
  logic       ram_seeded = 1'b0;
  always @(posedge clock) begin
    if (!ram_seeded) begin
      for (int i = 0; i < 8; i++) ram[i] <= {1'b1, 2'(i)};
      ram_seeded <= 1'b1;
    end else begin
      if (mem_enable && mem_we) ram[mem_addr] <= mem_data_in;
      if (!mem_we) mem_data_out <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since release, cycles left in the current transaction, shadow memory.
  int         cyc = 0;
  int         m_edges = 0;
  int         m_busy = 0;
  logic       m_op_wr = 1'b0;
  logic [2:0] m_op_addr = '0;
  logic [2:0] m_op_data = '0;
  logic [2:0] m_rdata = '0;
  logic [2:0] sm [8];
  logic       m_sweep_prev, m_idle_prev;

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_edges = 0;
      m_busy  = 0;
      m_rdata = '0;
    end else begin
      m_sweep_prev = (m_edges < 8);
      m_idle_prev  = !m_sweep_prev && (m_busy == 0);
      if (m_sweep_prev) sm[m_edges] = 3'd0;
      if (m_edges < 1000) m_edges++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 1 && !m_op_wr) m_rdata = sm[m_op_addr];
      end else if (m_idle_prev && req) begin
        m_op_wr   = wr;
        m_op_addr = addr;
        m_op_data = wdata;
        m_busy    = wr ? 2 : 3;
        if (wr) sm[addr] = wdata;
      end
    end
  end

  int   ack_cnt = 0;
  int   u1_we_cnt = 0;
  logic e_sweep, e_we;

  always @(negedge clock) begin
    if (mem_we1) u1_we_cnt++;
    if (!reset_n) begin
      chk("rst_ready", int'(ready), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_rdata", int'(rdata), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_enable", int'(mem_enable), 0);
    end else begin
      e_sweep = (m_edges < 8);
      e_we    = e_sweep || (m_busy == 2 && m_op_wr);
      chk("mon_ready", int'(ready), int'(!e_sweep && m_busy == 0));
      chk("mon_ack", int'(ack), int'(!e_sweep && m_busy == 1));
      chk("mon_rdata", int'(rdata), int'(m_rdata));
      chk("mon_mem_we", int'(mem_we), int'(e_we));
      chk("mon_mem_enable", int'(mem_enable), int'(e_we));
      if (e_sweep) begin
        chk("mon_sweep_addr", int'(mem_addr), m_edges);
        chk("mon_sweep_data", int'(mem_data_in), 0);
      end else if (e_we) begin
        chk("mon_wr_addr", int'(mem_addr), int'(m_op_addr));
        chk("mon_wr_data", int'(mem_data_in), int'(m_op_data));
      end
      if (ack) ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", int'(ready), 1);
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    while (!ack && k < 10) begin
      tick();
      k++;
    end
  endtask

  int n_tx = 0;

  task automatic xact(input logic w, input logic [2:0] a, input logic [2:0] d,
                      output int lat, output logic [2:0] rd);
    int k;
    wait_ready();
    req = 1'b1; wr = w; addr = a; wdata = d;
    tick();
    req = 1'b0; wr = 1'b0;
    wait_ack(k);
    lat = k + 1;
    rd = rdata;
    n_tx++;
    tick();
  endtask

  int         lat, k, n_we, early;
  int         ack_cyc [3];
  logic [2:0] rd;
  logic [2:0] b2b_a [3];
  logic [2:0] b2b_d [3];

  initial begin
    b2b_a[0] = 3'd1; b2b_a[1] = 3'd2; b2b_a[2] = 3'd7;
    b2b_d[0] = 3'd3; b2b_d[1] = 3'd4; b2b_d[2] = 3'd7;

    repeat (3) tick();
    reset_n = 1'b1;
    rst1_n  = 1'b1;
    n_we  = 0;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) chk("noclr_ready_first_cycle", int'(ready1), 1);
      if (mem_we && mem_enable && mem_addr == 3'(i) && mem_data_in == 3'd0) n_we++;
      if (ready) early++;
      if (i == 2) begin req = 1'b1; wr = 1'b1; addr = 3'd2; wdata = 3'd5; end
      if (i == 5) begin req = 1'b0; wr = 1'b0; end
    end
    @(negedge clock);
    chk("sweep_we_cycles", n_we, 8);
    chk("sweep_ready_early", early, 0);
    chk("ready_9th_cycle", int'(ready), 1);
    chk("ack_during_sweep", ack_cnt, 0);

    for (int a = 0; a < 8; a++) begin
      xact(1'b0, 3'(a), 3'd0, lat, rd);
      chk("cleared_word", int'(rd), 0);
    end

    xact(1'b1, 3'd5, 3'd6, lat, rd);
    chk("write_latency", lat, 2);
    xact(1'b0, 3'd5, 3'd0, lat, rd);
    chk("read_latency", lat, 3);
    chk("read_data_at_ack", int'(rd), 6);
    chk("rdata_held_after_ack", int'(rdata), 6);

    // Read of 5 with req still high (as a write of 1) during RD: must be ignored.
    wait_ready();
    req = 1'b1; wr = 1'b0; addr = 3'd5;
    tick();
    wr = 1'b1; wdata = 3'd1;
    tick();
    req = 1'b0; wr = 1'b0;
    wait_ack(k);
    chk("rd_ignore_latency", k + 2, 3);
    chk("rd_ignore_data", int'(rdata), 6);
    n_tx++;
    tick();
    xact(1'b0, 3'd5, 3'd0, lat, rd);
    chk("no_write_during_rd", int'(rd), 6);

    wait_ready();
    req = 1'b1; wr = 1'b1; addr = b2b_a[0]; wdata = b2b_d[0];
    for (int j = 0; j < 3; j++) begin
      wait_ack(k);
      ack_cyc[j] = cyc;
      n_tx++;
      if (j < 2) begin
        addr = b2b_a[j+1]; wdata = b2b_d[j+1];
      end else begin
        req = 1'b0; wr = 1'b0;
      end
      tick();
    end
    chk("b2b_spacing_01", ack_cyc[1] - ack_cyc[0], 3);
    chk("b2b_spacing_12", ack_cyc[2] - ack_cyc[1], 3);
    xact(1'b0, 3'd1, 3'd0, lat, rd);
    chk("b2b_read_1", int'(rd), 3);
    xact(1'b0, 3'd2, 3'd0, lat, rd);
    chk("b2b_read_2", int'(rd), 4);
    xact(1'b0, 3'd7, 3'd0, lat, rd);
    chk("b2b_read_7", int'(rd), 7);

    xact(1'b1, 3'd3, 3'd5, lat, rd);
    wait_ready();
    req = 1'b1; wr = 1'b0; addr = 3'd3;
    tick();
    req = 1'b0;
    tick();
    chk("pre_reset_rdata", int'(rdata), 7);
    reset_n = 1'b0;
    #1;
    chk("abort_rdata", int'(rdata), 0);
    chk("abort_mem_we", int'(mem_we), 0);
    chk("abort_ack", int'(ack), 0);
    chk("abort_ready", int'(ready), 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("restart_sweep_we", int'(mem_we), 1);
    chk("restart_sweep_addr", int'(mem_addr), 0);
    xact(1'b0, 3'd3, 3'd0, lat, rd);
    chk("reswept_word", int'(rd), 0);

    tick();
    chk("ack_total", ack_cnt, n_tx);
    chk("noclr_mem_we_count", u1_we_cnt, 0);
    chk("noclr_ready", int'(ready1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Initiator-side controller for the processor's 3-bit synchronous data RAM.
- Accepts single-word read/write requests from the processor datapath over a req/ack handshake and generates the RAM's we/enable/addr/data_in strobes.
- Captures the RAM's registered read data and returns it to the processor.
- After reset, sweeps the RAM and writes a known value to every word, because the RAM array itself has no reset.

Parameters:
- DATA_W, 3, data word width (matches RAM word).
- ADDR_W, 3, address width.
- DEPTH, 8, number of words cleared after reset; must be ≤ 2^ADDR_W.
- CLEAR_VAL, 0, value written to each word during the post-reset sweep.
- CLEAR_EN, 1, 1 = run the sweep after reset; 0 = go straight to IDLE.

Ports:
- clock  input  1  processor clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  processor request strobe; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_W  word address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- ready  output  1  high only in IDLE (sweep finished, no transaction in flight).
- ack  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read result; valid while ack is high and held until the next read completes.
- mem_we  output  1  to RAM we.
- mem_enable  output  1  to RAM enable.
- mem_addr  output  ADDR_W  to RAM addr.
- mem_data_in  output  DATA_W  to RAM data_in.
- mem_data_out  input  DATA_W  from RAM data_out; registered inside the RAM on a clock edge with we=0.

Behaviour:
- States: CLEAR, IDLE, WR, RD, RD_CAP, ACK.
- Registers: state, clr_cnt, addr_q, wdata_q, rdata.

Reset (reset_n low, asynchronous):
- state = CLEAR if CLEAR_EN, else IDLE.
- clr_cnt = 0; addr_q = 0; wdata_q = 0; rdata = 0; ack = 0.
- mem_we, mem_enable, mem_addr and mem_data_in are forced to 0 while reset_n is low.
- A reset mid-transaction abandons the transaction; no ack is issued.

CLEAR:
- Drive mem_we=1, mem_enable=1, mem_addr=clr_cnt, mem_data_in=CLEAR_VAL.
- clr_cnt increments each cycle.
- When clr_cnt==DEPTH-1: go to IDLE at that edge.
- The sweep takes exactly DEPTH cycles; ready rises after the DEPTH-th edge following reset release.
- req is ignored in CLEAR.

IDLE:
- ready=1; mem_we=0, mem_enable=0, mem_addr=addr_q.
- The RAM performs harmless reads in this state.
- req=1 and wr=1: latch addr and wdata, go to WR.
- req=1 and wr=0: latch addr, go to RD.

WR (one cycle):
- mem_we=1, mem_enable=1, mem_addr=addr_q, mem_data_in=wdata_q.
- RAM writes at the closing edge; go to ACK.

RD (one cycle):
- mem_we=0, mem_addr=addr_q.
- RAM loads data_out at the closing edge; go to RD_CAP.

RD_CAP:
- mem_we=0, mem_addr=addr_q.
- rdata <= mem_data_out at the closing edge; go to ACK.

ACK:
- ack=1 for exactly one cycle; go to IDLE.
- mem_we=0.
- The requester must drop req by the end of the ACK cycle; a req still high in the following IDLE cycle starts a new transaction.

Latency (req sampled at edge E0):
- Write: ack is high in the cycle after E2's predecessor, i.e. 2 edges after E0.
- Read: ack is high 3 edges after E0.
- Back-to-back throughput: one write per 3 cycles, one read per 4 cycles, counting the IDLE cycle.

Other rules:
- Requests arriving outside IDLE are neither queued nor acknowledged.
- addr, wr and wdata are don't-care outside the request-sampling edge.
- mem_enable is high only in CLEAR and WR; mem_we is never high without mem_enable.
- Addresses ≥ DEPTH are passed through unchanged; out-of-range handling belongs to the RAM.

Test Plan:
- Reset release with CLEAR_EN=1 and DEPTH=8 -> mem_we high for exactly 8 cycles with mem_addr 0..7 and data 0; ready rises on the 9th cycle; reading any address 0..7 returns 0.
- Write addr=5, wdata=6, then read addr=5 -> write ack 2 edges after its req edge; read ack 3 edges after its req edge with rdata=6; rdata still 6 after ack falls.
- Back-to-back writes to addr 1=3, 2=4, 7=7 with req held through each ack, then read all three -> acks spaced 3 cycles apart; read data returned is 3, 4, 7.
- req pulsed during CLEAR and during a RD in progress -> no extra ack, no RAM write, state unaffected.
- reset_n asserted during RD_CAP of a read of addr 3 (holding 5) -> no ack; rdata=0 immediately; mem_we=0 while reset is low; sweep restarts from address 0 on release.
- CLEAR_EN=0 -> ready=1 on the first cycle after reset release and mem_we is never asserted before the first write request.
